// File: rtl/red_led_ctrl.sv
// Register-programmed sequencer for the red LED bank: static, blink and rotate
// chase modes on a prescaled tick, with global PWM dimming and bus readback.
module red_led_ctrl #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 50000,
  parameter int PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic [WIDTH-1:0] led_out,
  output logic             step
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTL   = 2'd2;
  localparam logic [1:0] MODE_ROTR   = 2'd3;

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_DUTY    = 2'd3;

  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         period_q, period_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                phase_q, phase_d;
  logic [PS_W-1:0]     prescale_cnt_q, prescale_cnt_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                step_q, step_d;

  logic        tick;
  logic [15:0] period_eff;
  logic [16:0] step_cnt_inc;
  logic        step_event;
  logic        pwm_on;

  assign tick         = (prescale_cnt_q == PS_LAST);
  assign period_eff   = (period_q == 16'd0) ? 16'd1 : period_q;
  assign step_cnt_inc = {1'b0, step_cnt_q} + 17'd1;
  // A bus write in the same cycle always pre-empts the step.
  assign step_event   = tick && !we && (step_cnt_inc >= {1'b0, period_eff});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q      <= '0;
      work_q         <= '0;
      mode_q         <= MODE_STATIC;
      period_q       <= 16'd1;
      duty_q         <= '1;
      phase_q        <= 1'b1;
      prescale_cnt_q <= '0;
      step_cnt_q     <= '0;
      pwm_cnt_q      <= '0;
      led_q          <= '0;
      rdata_q        <= '0;
      step_q         <= 1'b0;
    end else begin
      pattern_q      <= pattern_d;
      work_q         <= work_d;
      mode_q         <= mode_d;
      period_q       <= period_d;
      duty_q         <= duty_d;
      phase_q        <= phase_d;
      prescale_cnt_q <= prescale_cnt_d;
      step_cnt_q     <= step_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      led_q          <= led_d;
      rdata_q        <= rdata_d;
      step_q         <= step_d;
    end
  end

  // Next-state: free-running counters, register writes and step sequencing
  always_comb begin
    pattern_d      = pattern_q;
    work_d         = work_q;
    mode_d         = mode_q;
    period_d       = period_q;
    duty_d         = duty_q;
    phase_d        = phase_q;
    step_cnt_d     = step_cnt_q;
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + PS_W'(1);
    pwm_cnt_d      = pwm_cnt_q + PWM_BITS'(1);

    if (we) begin
      case (addr)
        ADDR_PATTERN: begin
          pattern_d  = WIDTH'(wdata);
          work_d     = WIDTH'(wdata);
          phase_d    = 1'b1;
          step_cnt_d = '0;
        end
        ADDR_MODE: begin
          mode_d     = wdata[1:0];
          work_d     = pattern_q;
          phase_d    = 1'b1;
          step_cnt_d = '0;
        end
        ADDR_PERIOD: begin
          period_d   = wdata;
          step_cnt_d = '0;
        end
        default: begin
          duty_d = wdata[PWM_BITS-1:0];
        end
      endcase
    end else if (tick) begin
      if (step_event) begin
        step_cnt_d = '0;
        case (mode_q)
          MODE_BLINK: phase_d = !phase_q;
          MODE_ROTL:  work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
          MODE_ROTR:  work_d  = {work_q[0], work_q[WIDTH-1:1]};
          default:    work_d  = work_q;
        endcase
      end else begin
        step_cnt_d = step_cnt_inc[15:0];
      end
    end
  end

  // Outputs: dimmed LED drive, step pulse and readback mux
  always_comb begin
    pwm_on = (duty_q == '1) || (pwm_cnt_q < duty_q);
    led_d  = '0;
    if (!(mode_q == MODE_BLINK && !phase_q) && pwm_on) begin
      led_d = work_q;
    end
    step_d = step_event;
    case (addr)
      ADDR_PATTERN: rdata_d = 16'(pattern_q);
      ADDR_MODE:    rdata_d = {14'd0, mode_q};
      ADDR_PERIOD:  rdata_d = period_q;
      default:      rdata_d = 16'(duty_q);
    endcase
  end

  assign led_out = led_q;
  assign rdata   = rdata_q;
  assign step    = step_q;

endmodule

// File: tb/tb_red_led_ctrl.sv
// Self-checking bench for red_led_ctrl: directed scenarios plus random bus
// traffic, all compared every cycle against a behavioural reference model.
module tb_red_led_ctrl;
  localparam int W  = 16;
  localparam int P  = 4;
  localparam int PB = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         we = 1'b0;
  logic [1:0]   addr = 2'd0;
  logic [15:0]  wdata = 16'd0;
  logic [15:0]  rdata;
  logic [W-1:0] led_out;
  logic         step;

  always #5 clk = ~clk;

  red_led_ctrl #(.WIDTH(W), .PRESCALE(P), .PWM_BITS(PB)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led_out(led_out), .step(step)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, plain integers
  int m_pat, m_work, m_mode, m_period, m_duty, m_phase;
  int m_scnt, m_pres, m_pwm, m_led, m_rdata, m_step;

  function automatic int rotl(input int w);
    return ((w * 2) % 65536) + (w / 32768);
  endfunction

  function automatic int rotr(input int w);
    return (w / 2) + (w % 2) * 32768;
  endfunction

  task automatic model_reset();
    m_pat = 0; m_work = 0; m_mode = 0; m_period = 1; m_duty = 255; m_phase = 1;
    m_scnt = 0; m_pres = 0; m_pwm = 0; m_led = 0; m_rdata = 0; m_step = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs now applied
  task automatic model_edge();
    int  eff, regs[4], d;
    bit  tk, on, ev;
    eff = (m_period < 1) ? 1 : m_period;
    tk  = (m_pres == P - 1);
    on  = (m_duty == 255) || (m_pwm < m_duty);
    ev  = tk && !we && (m_scnt + 1 >= eff);
    regs[0] = m_pat; regs[1] = m_mode; regs[2] = m_period; regs[3] = m_duty;
    m_led   = (m_mode == 1 && m_phase == 0) ? 0 : (on ? m_work : 0);
    m_rdata = regs[addr];
    m_step  = ev ? 1 : 0;
    d = int'(wdata);
    if (we) begin
      case (addr)
        2'd0: begin m_pat = d; m_work = d; m_phase = 1; m_scnt = 0; end
        2'd1: begin m_mode = d % 4; m_work = m_pat; m_phase = 1; m_scnt = 0; end
        2'd2: begin m_period = d; m_scnt = 0; end
        default: m_duty = d % 256;
      endcase
    end else if (tk) begin
      if (ev) begin
        m_scnt = 0;
        if (m_mode == 1) m_phase = 1 - m_phase;
        else if (m_mode == 2) m_work = rotl(m_work);
        else if (m_mode == 3) m_work = rotr(m_work);
      end else begin
        m_scnt = m_scnt + 1;
      end
    end
    m_pres = (m_pres + 1) % P;
    m_pwm  = (m_pwm + 1) % 256;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("led_out", 32'(led_out), m_led);
    check("step", 32'(step), m_step);
    check("rdata", 32'(rdata), m_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  // Waits (bounded) for the step pulse; n returns the cycles waited
  task automatic wait_step(output int n);
    n = 0;
    while (step !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    check("step_seen", 32'(step), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_led", 32'(led_out), 0);
    check("rst_step", 32'(step), 0);
    check("rst_rdata", 32'(rdata), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int unsigned exp_v;
  int n, cnt;
  logic [15:0] rst_vals [4];

  initial begin
    rst_vals[0] = 16'h0000; rst_vals[1] = 16'h0000;
    rst_vals[2] = 16'h0001; rst_vals[3] = 16'h00FF;

    // Power-on reset
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_led", 32'(led_out), 0);
    check("por_rdata", 32'(rdata), 0);
    check("por_step", 32'(step), 0);
    @(negedge clk);
    reset = 1'b1;

    // Static pattern held
    wr(2'd0, 16'hA5A5);
    wr(2'd1, 16'h0000);
    cyc();
    check("static_led", 32'(led_out), 32'h0000A5A5);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (led_out === 16'hA5A5) cnt++;
    end
    check("static_hold", cnt, 1000);
    addr = 2'd0;
    cyc();
    check("rd_pattern", 32'(rdata), 32'h0000A5A5);

    // Rotate-left chase, PERIOD=2 -> one step per 8 cycles
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'd2);
    wr(2'd1, 16'd2);
    exp_v = 1;
    for (int k = 1; k <= 16; k++) begin
      wait_step(n);
      if (k > 1) check("rotl_interval", n + 1, 8);
      cyc();
      exp_v = rotl(exp_v);
      check("rotl_led", 32'(led_out), exp_v);
    end
    check("rotl_wrap", 32'(led_out), 1);

    // Rotate-right, PERIOD=1 -> one step per 4 cycles
    wr(2'd0, 16'h8001);
    wr(2'd2, 16'd1);
    wr(2'd1, 16'd3);
    wait_step(n);
    cyc();
    check("rotr_1", 32'(led_out), 32'h0000C000);
    wait_step(n);
    check("rotr_interval", n + 1, 4);
    cyc();
    check("rotr_2", 32'(led_out), 32'h00006000);

    // Blink, PERIOD=3 -> toggle every 12 cycles, then PERIOD=0 -> every 4
    wr(2'd0, 16'hFFFF);
    wr(2'd2, 16'd3);
    wr(2'd1, 16'd1);
    cyc();
    check("blink_on", 32'(led_out), 32'h0000FFFF);
    wait_step(n);
    cyc();
    check("blink_off", 32'(led_out), 0);
    wait_step(n);
    check("blink_interval", n + 1, 12);
    cyc();
    check("blink_on2", 32'(led_out), 32'h0000FFFF);
    wr(2'd2, 16'd0);
    wait_step(n);
    cyc();
    wait_step(n);
    check("blink_p0_interval", n + 1, 4);
    cyc();

    // PWM duty counts over one full period
    wr(2'd1, 16'd0);
    wr(2'd0, 16'hFFFF);
    for (int j = 0; j < 3; j++) begin
      wr(2'd3, (j == 0) ? 16'd64 : (j == 1) ? 16'd0 : 16'd255);
      cyc(); cyc();
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
        cyc();
        if (led_out === 16'hFFFF) cnt++;
      end
      check("pwm_on_count", cnt, (j == 0) ? 64 : (j == 1) ? 0 : 256);
    end

    // PATTERN write landing exactly on a step tick
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'd1);
    wr(2'd1, 16'd2);
    n = 0;
    while (m_pres != P - 1 && n < 10) begin
      cyc();
      n++;
    end
    check("tick_align", m_pres, P - 1);
    we = 1'b1; addr = 2'd0; wdata = 16'h0F00;
    cyc();
    we = 1'b0;
    check("wr_tick_step", 32'(step), 0);
    cyc();
    check("wr_tick_led", 32'(led_out), 32'h00000F00);

    // Random bus traffic
    for (int i = 0; i < 3000; i++) begin
      addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        we = 1'b1;
        wdata = (addr == 2'd2) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      end else begin
        we = 1'b0;
      end
      cyc();
    end
    we = 1'b0;

    // Reset mid-chase
    wr(2'd0, 16'h0003);
    wr(2'd3, 16'd255);
    wr(2'd1, 16'd2);
    repeat (10) cyc();
    pulse_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      cyc();
      check("rst_readback", 32'(rdata), 32'(rst_vals[a]));
    end
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (led_out !== '0) cnt++;
    end
    check("rst_led_dark", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/red_led_ctrl.md
Name: red_led_ctrl

Overview:
- Register-programmed controller that sequences the 16-bit red LED bank: static pattern, blink, rotate-left or rotate-right chase, with global PWM dimming.
- Sits between the CPU's simple bus (write/address/data) and the LED output driver.
- Its led_out feeds the LED driver's data input directly.

Parameters:
WIDTH, 16, LED bank width; pattern register width.
PRESCALE, 50000, clk cycles per tick; legal range 2 or more.
PWM_BITS, 8, PWM counter and duty width.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous active-low reset; clears all state while low.
we  input  1  register write strobe, one cycle per write.
addr  input  2  register select: 0 PATTERN, 1 MODE, 2 PERIOD, 3 DUTY.
wdata  input  16  write data.
rdata  output  16  registered readback of register at addr.
led_out  output  WIDTH  registered LED drive.
step  output  1  one-cycle pulse on each step event, for debug and sync.

Behaviour:
Reset values (reset low):
- PATTERN=0, work=0, MODE=0, PERIOD=1, DUTY=all-ones.
- phase=1, prescale_cnt=0, step_cnt=0, pwm_cnt=0.
- led_out=0, rdata=0, step=0.

Registers:
- PATTERN[WIDTH-1:0].
- MODE[1:0]: 0 static, 1 blink, 2 rotate-left, 3 rotate-right; upper wdata bits ignored, read as 0.
- PERIOD[15:0] in ticks; 0 behaves as 1.
- DUTY[PWM_BITS-1:0].

Prescaler:
- prescale_cnt counts 0..PRESCALE-1 and wraps.
- tick is asserted for the cycle in which prescale_cnt == PRESCALE-1.

Step counter:
- On tick, step_cnt increments.
- When tick occurs and step_cnt+1 >= max(PERIOD,1), this is a step event: step_cnt returns to 0 and step pulses high next cycle.

On a step event, by mode:
- Static: nothing changes.
- Blink: phase toggles.
- Rotate-left: work <= {work[WIDTH-2:0], work[WIDTH-1]}.
- Rotate-right: work <= {work[0], work[WIDTH-1:1]}.

Writes (take effect at the edge sampling we):
- PATTERN: PATTERN, work <= wdata; phase <= 1; step_cnt <= 0.
- MODE: MODE <= wdata[1:0]; work <= PATTERN; phase <= 1; step_cnt <= 0.
- PERIOD: PERIOD <= wdata; step_cnt <= 0.
- DUTY: DUTY <= wdata[PWM_BITS-1:0]; no sequencing state is disturbed.
- Write coinciding with a tick or step event: the write wins; no step is applied that cycle and step stays 0.
- prescale_cnt is never cleared by writes; tick phase is free-running.

PWM:
- pwm_cnt is free-running 0..2^PWM_BITS-1 and wraps.
- pwm_on = (DUTY == all-ones) or (pwm_cnt < DUTY).
- DUTY=0 means always off; DUTY all-ones means always on.

Output:
- led_out <= (mode==blink && !phase) ? 0 : (pwm_on ? work : 0).
- Registered, so led_out reflects new register state one cycle after the register update, i.e. 2 edges after we is sampled.

Readback:
- rdata <= selected register, zero-extended; 1-cycle latency.
- Write and read of the same address in the same cycle returns the old value.
- Reset asserted mid-sequence clears everything immediately; after release, led_out=0 until PATTERN is written.

Test Plan:
- PRESCALE=4. Reset, write PATTERN=16'hA5A5, MODE=0 -> led_out=16'hA5A5 two edges after we and held for 1000 cycles; rdata at addr 0 reads 16'hA5A5.
- PRESCALE=4, PATTERN=16'h0001, PERIOD=2, MODE=2 -> led_out steps 0001, 0002, 0004 every 8 cycles; after 16 steps back to 0001; step pulses align with changes.
- MODE=3 with PATTERN=16'h8001, PERIOD=1 -> next values C000 then 6000, one step per 4 cycles.
- MODE=1, PATTERN=16'hFFFF, PERIOD=3 -> led_out alternates FFFF/0000 every 12 cycles; PERIOD=0 write -> toggles every 4 cycles.
- PWM_BITS=8: DUTY=64 static FFFF -> exactly 64 of 256 cycles led_out=FFFF; DUTY=0 -> always 0; DUTY=255 -> always FFFF.
- Write PATTERN in the exact tick cycle of a step in rotate mode -> work = new pattern, no rotation, step=0. Pulse reset low mid-chase -> led_out=0 and all registers read back their reset values.
